store_buffer: RTL and testbench

- Posted-write buffer between the MEM pipeline stage and data_memory; sits directly upstream of it and owns its single port.
- Stores are queued and retire to memory one per cycle when no load needs the port. The CPU therefore never waits on store writes unless the buffer is full.
- Loads get the memory port with priority, and buffered data is forwarded to them so the CPU sees program-order values.

---
 rtl/store_buffer_pkg.sv | 20 ++
 rtl/sb_match.sv | 42 ++++
 rtl/store_buffer.sv | 147 ++++++++++++++
 tb/tb_store_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths and the buffered-store entry type for the
// posted-write store buffer and its youngest-match finder.
//   ADDR_W / DATA_W    : byte address and data widths of the memory port.
//   WORD_LSB..WORD_MSB : address bits that select a data_memory word.
//   IDX_W              : width of the word index used for load/store matching.
//   sb_entry_t         : one buffered store {addr, data}.
package store_buffer_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int WORD_LSB = 2;
    localparam int WORD_MSB = 9;
    localparam int IDX_W    = WORD_MSB - WORD_LSB + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// sb_match: combinational youngest-match finder over the store buffer slots.
// Ports:
//   valid    - per-slot occupied flag
//   idx      - per-slot word index of the buffered store
//   age      - per-slot distance from the head (larger = younger)
//   data     - per-slot buffered store data
//   lookup   - word index of the incoming load
//   hit      - at least one valid slot matches lookup
//   hit_data - data of the youngest matching slot (0 when no hit)
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][IDX_W-1:0]  idx,
    input  logic [DEPTH-1:0][PTR_W-1:0]  age,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [IDX_W-1:0]             lookup,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);

    logic [PTR_W-1:0] best_age;

    // Ages of occupied slots are distinct, so a strict compare selects exactly
    // one youngest match regardless of scan order.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (idx[i] == lookup) && (!hit || (age[i] > best_age))) begin
                hit      = 1'b1;
                hit_data = data[i];
                best_age = age[i];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer owning the single data_memory port.
// Stores are queued in a circular FIFO and retire one per cycle whenever no
// load is using the port; loads take the port with priority.
// Build option:
//   STORE_BUF_FWD_EN defined   - loads matching a buffered store are served
//                                from the youngest matching entry.
//   STORE_BUF_FWD_EN undefined - a matching load is stalled (req_ready=0) and
//                                the buffer drains instead until no entry
//                                matches, then the load reads memory.
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_write/req_addr/req_wdata - CPU request; req_ready accept
//   rd_data   - load result, same cycle as an accepted load, else 0
//   buf_empty - no stores pending
//   mem_access_addr/mem_write_data/mem_write_en/mem_read - to data_memory
//   mem_read_data - combinational read data from data_memory
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              buf_empty,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    sb_entry_t                    entries [DEPTH];
    logic [DEPTH-1:0]             valid;
    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [PTR_W:0]               count;

    logic [DEPTH-1:0][IDX_W-1:0]  ent_idx;
    logic [DEPTH-1:0][PTR_W-1:0]  ent_age;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    logic                         hit;
    logic [DATA_W-1:0]            fwd_data;
    logic                         is_load;
    logic                         is_store;
    logic                         full;
    logic                         load_go;
    logic                         drain;
    logic                         push;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign ent_idx[g]  = entries[g].addr[WORD_MSB:WORD_LSB];
        assign ent_data[g] = entries[g].data;
        assign ent_age[g]  = PTR_W'(g) - head;
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .valid    (valid),
        .idx      (ent_idx),
        .age      (ent_age),
        .data     (ent_data),
        .lookup   (req_addr[WORD_MSB:WORD_LSB]),
        .hit      (hit),
        .hit_data (fwd_data)
    );

    assign is_load  = req_valid & ~req_write;
    assign is_store = req_valid & req_write;
    assign full     = (count == (PTR_W+1)'(DEPTH));

`ifdef STORE_BUF_FWD_EN
    assign load_go = is_load;
    assign rd_data = load_go ? (hit ? fwd_data : mem_read_data) : '0;
`else
    // Without forwarding a matching load must wait until memory holds the
    // buffered value; the match result is only used to hold the load back.
    assign load_go = is_load & ~hit;
    assign rd_data = load_go ? mem_read_data : '0;
    logic unused_fwd;
    assign unused_fwd = ^fwd_data;
`endif

    // Drain is suppressed during reset so discarded stores never reach memory.
    assign drain     = ~reset & ~load_go & (count != '0);
    // A full buffer refuses the store even if the head drains this cycle.
    assign push      = is_store & ~full;
    assign req_ready = is_store ? ~full : ~(is_load & ~load_go);
    assign buf_empty = (count == '0);

    always_comb begin
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        if (load_go) begin
            mem_read        = 1'b1;
            mem_access_addr = req_addr;
        end else if (drain) begin
            mem_write_en    = 1'b1;
            mem_access_addr = entries[head].addr;
            mem_write_data  = entries[head].data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            // tail==head with both push and drain is impossible: empty blocks
            // drain and full blocks push.
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload carries no reset; occupancy is tracked by valid/count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: req_addr, data: req_wdata};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic [15:0] rd_data;
    logic        buf_empty;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rd_data         (rd_data),
        .buf_empty       (buf_empty),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    // data_memory stand-in driven by the DUT
    logic [15:0] dmem [256];
    assign mem_read_data = dmem[mem_access_addr[9:2]];
    always @(posedge clk) if (mem_write_en) dmem[mem_access_addr[9:2]] <= mem_write_data;

    // reference: pending stores in program order and committed memory image
    st_t         q[$];
    logic [15:0] ref_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 16'hC000 | 16'(i);
            ref_mem[i] = 16'hC000 | 16'(i);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model decisions taken at negedge, applied at the following posedge
    logic e_drain = 1'b0;
    logic e_push  = 1'b0;

    always @(negedge clk) begin
        logic        ld, st, m_hit, serve, e_ready, e_mr, e_we;
        logic [15:0] m_data, e_rd, e_addr, e_wd;
        e_drain = 1'b0;
        e_push  = 1'b0;
        if (!reset) begin
            ld = req_valid && !req_write;
            st = req_valid && req_write;
            m_hit = 1'b0;
            m_data = '0;
            foreach (q[i]) begin
                if (q[i].addr[9:2] == req_addr[9:2]) begin
                    m_hit  = 1'b1;
                    m_data = q[i].data;   // later in queue = younger
                end
            end
`ifdef STORE_BUF_FWD_EN
            serve = ld;
`else
            serve = ld && !m_hit;
`endif
            e_ready = 1'b1; e_mr = 1'b0; e_we = 1'b0;
            e_rd = '0; e_addr = '0; e_wd = '0;
            if (serve) begin
                e_mr   = 1'b1;
                e_addr = req_addr;
                e_rd   = m_hit ? m_data : ref_mem[req_addr[9:2]];
            end else if (q.size() > 0) begin
                e_we    = 1'b1;
                e_addr  = q[0].addr;
                e_wd    = q[0].data;
                e_drain = 1'b1;
            end
            if (ld && !serve) e_ready = 1'b0;
            if (st) begin
                e_ready = (q.size() < DEPTH);
                e_push  = e_ready;
            end
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
            chk("mem_read", 32'(mem_read), 32'(e_mr));
            chk("mem_write_en", 32'(mem_write_en), 32'(e_we));
            chk("mem_access_addr", 32'(mem_access_addr), 32'(e_addr));
            if (e_we || !e_mr) chk("mem_write_data", 32'(mem_write_data), 32'(e_wd));
            if (!ld || serve) chk("rd_data", 32'(rd_data), 32'(e_rd));
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (e_drain) begin
                ref_mem[q[0].addr[9:2]] = q[0].data;
                void'(q.pop_front());
            end
            if (e_push) q.push_back('{addr: req_addr, data: req_wdata});
        end
    end

    task automatic go_idle();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Hold a request until accepted; returns read data and cycles taken.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int ncyc);
        logic acc = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        rd = '0;
        ncyc = 0;
        for (int n = 0; n < 16 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready;
            rd  = rd_data;
            ncyc++;
            step();
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL handshake: got no accept for addr %h expected accept within 16 cycles", a);
        end
        go_idle();
    endtask

    initial begin
        logic [15:0] rd;
        int          nc;
        int          bad;
        logic        pend, acc;

        repeat (2) step();
        reset = 1'b0;

        // reset then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_empty", 32'(buf_empty), 32'd1);
            chk("idle_ready", 32'(req_ready), 32'd1);
            chk("idle_we", 32'(mem_write_en), 32'd0);
            chk("idle_rd", 32'(mem_read), 32'd0);
            step();
        end

        // single store, drain next cycle, then read back from memory
        issue(1'b1, 16'h0010, 16'hBEEF, rd, nc);
        @(negedge clk);
        chk("drain_we", 32'(mem_write_en), 32'd1);
        chk("drain_addr", 32'(mem_access_addr), 32'h0010);
        chk("drain_data", 32'(mem_write_data), 32'hBEEF);
        step();
        @(negedge clk);
        chk("drained_empty", 32'(buf_empty), 32'd1);
        step();
        issue(1'b0, 16'h0010, 16'h0000, rd, nc);
        chk("load_beef", 32'(rd), 32'hBEEF);

        // back-to-back stores never stall
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 16'(k * 4), 16'h1000 + 16'(k), rd, nc);
            chk("b2b_cycles", 32'(nc), 32'd1);
        end
        // stores interleaved with loads
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 16'(k * 4), 16'h2000 + 16'(k), rd, nc);
            issue(1'b0, 16'h0040, 16'h0000, rd, nc);
        end
        repeat (3) step();

        // two stores to the same word, then an immediate load
        issue(1'b1, 16'h0020, 16'h1111, rd, nc);
        issue(1'b1, 16'h0020, 16'h2222, rd, nc);
        issue(1'b0, 16'h0020, 16'h0000, rd, nc);
        chk("fwd_youngest", 32'(rd), 32'h2222);
`ifdef STORE_BUF_FWD_EN
        chk("fwd_no_stall", 32'(nc), 32'd1);
`else
        chk("nofwd_stalls", 32'(nc > 1), 32'd1);
`endif

        // index alias: 0x0400 and 0x0000 share word index 0
        issue(1'b1, 16'h0400, 16'hAAAA, rd, nc);
        issue(1'b0, 16'h0000, 16'h0000, rd, nc);
        chk("alias", 32'(rd), 32'hAAAA);

        // reset while a store is pending discards it
        issue(1'b1, 16'h0080, 16'h5555, rd, nc);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_empty", 32'(buf_empty), 32'd1);
        chk("rst_we", 32'(mem_write_en), 32'd0);
        step();
        issue(1'b0, 16'h0080, 16'h0000, rd, nc);
        chk("rst_discard", 32'(rd), 32'hC020);

        // randomized traffic over a small word window
        pend = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!pend) begin
                req_valid = ($urandom_range(0, 9) < 7);
                req_write = 1'($urandom_range(0, 1));
                req_addr  = {6'($urandom), 8'($urandom_range(0, 7)), 2'($urandom)};
                req_wdata = 16'($urandom);
            end
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            acc = req_ready;
            step();
            pend = req_valid && !acc && !reset;
        end
        reset = 1'b0;
        go_idle();
        repeat (10) step();

        bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) bad++;
        chk("mem_image", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
